// File: rtl/usb_pkg.sv
// Shared encodings for the USB upload scheduler: source ids, mode codes,
// FSM state and the header word layout.
package usb_pkg;

    typedef enum logic {
        SRC_FFT = 1'b0,
        SRC_RAW = 1'b1
    } src_t;

    typedef enum logic [1:0] {
        MODE_FFT   = 2'b00,
        MODE_RAW   = 2'b01,
        MODE_ALT   = 2'b10,
        MODE_FIRST = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;

    // Header layout: magic in the upper half, source id in bit 15, frame sequence below.
    function automatic logic [31:0] hdr_word(input logic [15:0] magic, input src_t src,
                                             input logic [14:0] seq);
        return {magic, src, seq};
    endfunction

endpackage

// File: rtl/usb_stream_sched_if.sv
// 32-bit valid/ready stream bundle used for both producers and the serializer side.
// Handshake: a word moves on a rising ifclk edge when valid && ready; a master keeps
// valid and data stable until that happens, and ready may be asserted independently of valid.
interface usb_stream_sched_if;
    logic        valid;
    logic [31:0] data;
    logic        ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/usb_src_mux.sv
// 2:1 valid/ready mux between the FFT and raw producers; the select is latched
// at frame boundaries and the unselected producer always sees ready=0.
module usb_src_mux
    import usb_pkg::*;
(
    input  logic                    ifclk,
    input  logic                    reset,
    input  logic                    load,
    input  src_t                    load_src,
    input  logic                    active,
    usb_stream_sched_if.slave       fft,
    usb_stream_sched_if.slave       raw,
    output src_t                    sel,
    output logic                    sel_valid,
    output logic [31:0]             sel_data,
    input  logic                    sel_ready
);

    always_ff @(posedge ifclk) begin
        if (reset) begin
            sel <= SRC_FFT;
        end else if (load) begin
            sel <= load_src;
        end
    end

    // Ready only flows back while the top is passing data, so headers never consume a word.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        fft.ready = 1'b0;
        raw.ready = 1'b0;
        if (sel == SRC_FFT) begin
            sel_valid = fft.valid;
            sel_data  = fft.data;
            fft.ready = active && sel_ready;
        end else begin
            sel_valid = raw.valid;
            sel_data  = raw.data;
            raw.ready = active && sel_ready;
        end
    end

endmodule

// File: rtl/usb_stream_sched.sv
// Frame scheduler sharing the FX2 upload stream between the FFT and raw producers:
// header word, then FRAME_WORDS data words from the source latched for that frame.
module usb_stream_sched
    import usb_pkg::*;
#(
    parameter int          FRAME_WORDS = 1024,
    parameter logic [15:0] HDR_MAGIC   = HDR_MAGIC_DEF,
    parameter int          CNT_W       = 16
) (
    input  logic                ifclk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    usb_stream_sched_if.slave   fft,
    usb_stream_sched_if.slave   raw,
    usb_stream_sched_if.master  out,
    output logic                frame_start,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output state_t              dbg_state
);

    state_t            state;
    src_t              sel;
    src_t              alt_next;
    src_t              pick_src;
    logic              pick_ok;
    logic              sel_valid;
    logic [31:0]       sel_data;
    logic [31:0]       hdr_q;
    logic [14:0]       seq;
    logic [CNT_W-1:0]  cnt;
    logic              xfer;
    logic              last_word;
    logic              boundary;
    logic              load;

    usb_src_mux u_mux (
        .ifclk     (ifclk),
        .reset     (reset),
        .load      (load),
        .load_src  (pick_src),
        .active    (state == ST_DATA),
        .fft       (fft),
        .raw       (raw),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_data  (sel_data),
        .sel_ready (out.ready)
    );

    // First-valid mode may find nothing to send; the boundary then falls back to IDLE.
    always_comb begin
        pick_ok  = 1'b1;
        pick_src = SRC_FFT;
        case (mode_t'(mode))
            MODE_FFT: pick_src = SRC_FFT;
            MODE_RAW: pick_src = SRC_RAW;
            MODE_ALT: pick_src = alt_next;
            default: begin
                if (fft.valid) begin
                    pick_src = SRC_FFT;
                end else if (raw.valid) begin
                    pick_src = SRC_RAW;
                end else begin
                    pick_ok = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        out.valid = 1'b0;
        out.data  = '0;
        case (state)
            ST_HDR: begin
                out.valid = 1'b1;
                out.data  = hdr_q;
            end
            ST_DATA: begin
                out.valid = sel_valid;
                out.data  = sel_data;
            end
            default: ;
        endcase
    end

    assign xfer      = out.valid && out.ready;
    assign last_word = (state == ST_DATA) && (cnt == CNT_W'(FRAME_WORDS - 1));
    assign boundary  = (state == ST_IDLE) || (xfer && last_word);
    assign load      = boundary && enable && pick_ok;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hdr_q       <= '0;
            seq         <= '0;
            cnt         <= '0;
            frame_cnt   <= '0;
            alt_next    <= SRC_FFT;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (load) begin
                hdr_q <= hdr_word(HDR_MAGIC, pick_src, seq);
                if (mode_t'(mode) == MODE_ALT) begin
                    alt_next <= (alt_next == SRC_FFT) ? SRC_RAW : SRC_FFT;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out.ready) begin
                        seq         <= seq + 15'd1;
                        frame_start <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (last_word) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= load ? ST_HDR : ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_stream_sched.md
Name: usb_stream_sched

Overview:
Scheduler in front of the FX2 slave-FIFO serializer. It shares the single 32-bit USB upload path between two producers: the FFT spectrum stream and the raw ADC sample stream. Data is sent in fixed-length frames, each preceded by a header word. It presents one valid/ready 32-bit stream to the serializer and holds the non-selected producer off.

Parameters:
FRAME_WORDS, 1024, data words per frame (header excluded); legal range 2..65535
HDR_MAGIC, 16'hA55A, upper half of every header word
CNT_W, 16, width of the internal data-word counter; must hold FRAME_WORDS

Ports:
ifclk  in  1  system/USB interface clock
reset  in  1  synchronous, active-high
enable  in  1  streaming request; sampled at frame boundaries only
mode  in  2  00 FFT only, 01 raw only, 10 alternate frames, 11 first-valid (FFT wins ties)
fft_valid  in  1  FFT word available
fft_data  in  32  FFT float word
fft_ready  out  1  FFT word consumed this cycle
raw_valid  in  1  raw word available
raw_data  in  32  raw sample word
raw_ready  out  1  raw word consumed this cycle
out_valid  out  1  word offered to serializer
out_data  out  32  word to serializer
out_ready  in  1  serializer accepts (registered ready from serializer)
frame_start  out  1  one-cycle pulse when a header is accepted
busy  out  1  high in any state except IDLE
frame_cnt  out  16  completed frames, wraps at 16'hFFFF->0

Behaviour:
- Reset values: out_valid=0, out_data=0, fft_ready=0, raw_ready=0, frame_start=0, busy=0, frame_cnt=0, seq=0, alt_next=FFT, state=IDLE.
- Transfer definition: out_valid && out_ready on a rising edge of ifclk.
- States:
  - IDLE: if enable=1, select src and go to HDR; otherwise stay in IDLE.
  - HDR: out_valid=1 (registered), out_data={HDR_MAGIC, src_id, seq[14:0]} with src_id 0=FFT, 1=raw. On transfer: seq<=seq+1 (15-bit wrap), frame_start=1 for one cycle, word counter cleared, go to DATA.
  - DATA: combinational pass-through of the selected source: out_valid=sel_valid, out_data=sel_data, sel_ready=out_ready. The other source's ready is 0. Each transfer increments the counter. On the FRAME_WORDS-th transfer: frame_cnt+1; go to HDR with a new selection if enable=1, else go to IDLE.
- Source selection (IDLE->HDR or DATA->HDR):
  - mode 00: FFT.
  - mode 01: raw.
  - mode 10: alt_next, which toggles on each selection.
  - mode 11: FFT if fft_valid, else raw if raw_valid, else stay or return to IDLE without emitting a header.
- Selection is latched for the whole frame; changes to mode mid-frame are ignored.
- out_data is held stable while out_valid=1 and out_ready=0. A header is never withdrawn once offered.
- Deasserting enable mid-frame: the frame is completed, then the block goes to IDLE. No partial frames.
- Source stalls in DATA (sel_valid=0): out_valid=0, counter holds, no timeout.
- Reset mid-frame: immediate abandon and return to reset values; the next frame starts with seq=0.
- Latency: the header is offered 1 cycle after IDLE sees enable; the first data word can transfer 1 cycle after the header transfer.
- fft_ready and raw_ready are never both 1 in the same cycle.

Decomposition:
- Shared package usb_pkg: src_id encoding (SRC_FFT=0, SRC_RAW=1), mode encodings, HDR_MAGIC default, state enum.
- One natural sub-module: usb_src_mux (2:1 valid/ready mux with latched select).
- Header/counter logic stays in the top module.

Test Plan:
- mode=00, FRAME_WORDS=4, enable=1, fft always valid, out_ready=1 → out_data sequence A55A0000, f0..f3, A55A0001, f4..f7. raw_ready stays 0 throughout. frame_start pulses on both header cycles.
- mode=10, FRAME_WORDS=2 → headers A55A0000 (FFT), A55A8001 (raw), A55A0002 (FFT), with data taken from the matching source each frame.
- out_ready toggling 1-0-1 during HDR and DATA → out_data held stable while stalled. Word count is exactly 4 per frame. No duplicated or dropped words.
- enable dropped after the 2nd data word of 4 → remaining 2 words still sent, then IDLE, busy=0, frame_cnt=1, no further header.
- mode=11, only raw_valid=1 at boundary → raw selected (src_id=1). With both valid → FFT selected.
- reset asserted on the 3rd data word → next cycle all outputs at reset values. After re-enable, the header is A55A0000 and frame_cnt=0.
